// File: rtl/game_key_ctrl.sv
// Four-key debouncer with press strobes and optional auto-repeat; key_level/key_pulse are registered.
// Each key: 2-flop synchroniser, stability counter, and an IDLE/DELAY/REPEAT repeat FSM.
module game_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    output logic [3:0] key_level,
    output logic [3:0] key_pulse
);

    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES);
    localparam logic [RCW-1:0] RD_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RP_LAST  = RCW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;

    logic [3:0]     meta_q, sync_q;
    logic [3:0]     level_q, level_d;
    logic [3:0]     pulse_q, pulse_d;
    logic [DCW-1:0] dcnt_q [4];
    logic [DCW-1:0] dcnt_d [4];
    logic [RCW-1:0] rcnt_q [4];
    logic [RCW-1:0] rcnt_d [4];
    rep_state_e     state_q [4];
    rep_state_e     state_d [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dcnt_q[i]  <= '0;
                rcnt_q[i]  <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            meta_q  <= key_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 4; i++) begin
                dcnt_q[i]  <= dcnt_d[i];
                rcnt_q[i]  <= rcnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        state_d = state_q;
        for (int i = 0; i < 4; i++) begin
            // dcnt counts completed mismatching cycles; a change is accepted once it has
            // held for DEBOUNCE_CYCLES full cycles and still mismatches on the current one.
            if (sync_q[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DEB_LAST) begin
                level_d[i] = sync_q[i];
                dcnt_d[i]  = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + 1'b1;
            end

            pulse_d[i] = level_d[i] & ~level_q[i];

            // Looking at level_d makes release win over a repeat due on the same edge.
            if (!level_d[i]) begin
                state_d[i] = IDLE;
                rcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (pulse_d[i] && (REPEAT_EN != 0)) begin
                            state_d[i] = DELAY;
                            rcnt_d[i]  = '0;
                        end
                    end
                    DELAY: begin
                        if (rcnt_q[i] == RD_LAST) begin
                            pulse_d[i] = 1'b1;
                            state_d[i] = REPEAT;
                            rcnt_d[i]  = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rcnt_q[i] == RP_LAST) begin
                            pulse_d[i] = 1'b1;
                            rcnt_d[i]  = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    assign key_level = level_q;
    assign key_pulse = pulse_q;

endmodule
